reg_writeback_stage: RTL and testbench
======================================

Name: reg_writeback_stage

Overview:
- Writer side of the 32x32 register file: MEM/WB pipeline register plus write-back datapath for the MIPS pipeline.
- Drives the register file write port (Din/Addr_Wr/wr).
- Bypasses the value being written this cycle onto the decode-stage read data, because the file reads asynchronously but writes on posedge.
- Counts retired instructions for debug.

Parameters:
- DATA_W, 32, register/data width
- ADDR_W, 5, register address width (32 registers)

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  synchronous reset, active-high
- stall  in  1  hold MEM/WB contents
- flush  in  1  load a bubble into MEM/WB
- mem_valid  in  1  MEM stage holds a real instruction
- mem_reg_write  in  1  instruction writes a register
- mem_mem_to_reg  in  1  1 = load data, 0 = ALU result
- mem_alu_result  in  DATA_W  ALU result from MEM
- mem_load_data  in  DATA_W  data memory read data
- mem_dest  in  ADDR_W  destination register
- rf_din  out  DATA_W  to register file Din
- rf_addr_wr  out  ADDR_W  to register file Addr_Wr
- rf_wr  out  1  to register file wr
- rd_addr_a  in  ADDR_W  decode read address A (= Addr_A)
- rd_addr_b  in  ADDR_W  decode read address B (= Addr_B)
- rf_port_a  in  DATA_W  register file Port_A
- rf_port_b  in  DATA_W  register file Port_B
- fwd_port_a  out  DATA_W  bypassed operand A to decode
- fwd_port_b  out  DATA_W  bypassed operand B to decode
- retired_count  out  32  retired-instruction counter

Behaviour:
- Reset: all MEM/WB fields cleared. wb_valid=0, rf_wr=0, rf_din=0, rf_addr_wr=0, retired_count=0. Reset has priority over stall and flush. Reset mid-stall discards the held entry.
- MEM/WB update at posedge, in priority order:
  - rst: clear.
  - else flush: wb_valid<=0, other fields don't-care, hold allowed.
  - else stall: hold all fields.
  - else capture all mem_* inputs.
- Write port is combinational from MEM/WB state:
  - rf_din = wb_mem_to_reg ? wb_load : wb_alu
  - rf_addr_wr = wb_dest
  - rf_wr = wb_valid & wb_reg_write & (wb_dest != 0)
- Writes to r0 are always suppressed, so r0 stays 0.
- Latency: a MEM-stage instruction captured at edge N is written into the register file at edge N+1.
- Stall with a valid writing entry re-asserts rf_wr with the same data each cycle. This is idempotent, and allowed.
- Flush does not cancel the entry currently in WB. Its write still completes at the flushing edge.
- retired_count increments by 1 at each posedge where wb_valid & (!stall | flush), i.e. when an entry leaves WB.
  - Counts once per entry regardless of stall length.
  - Includes non-writing instructions and dest=r0.
  - Wraps 0xFFFFFFFF -> 0.
- Bypass, per port X in {a,b}, combinational:
  - rd_addr_x == 0 -> fwd_port_x = 0
  - else rf_wr & (rd_addr_x == rf_addr_wr) -> fwd_port_x = rf_din
  - else fwd_port_x = rf_port_x
- A and B may hit the same address simultaneously. Both ports receive rf_din.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: bypass as above.
- Undefined:
  - fwd_port_a = rf_port_a and fwd_port_b = rf_port_b, with no r0 forcing.
  - Hazard control must stall decode one extra cycle on WB->ID dependencies.
- rf_wr, counter and pipeline register behaviour are identical either way.

Decomposition:
- Shared package contents:
  - DATA_W and ADDR_W constants
  - REG_ZERO = 5'd0
  - mem_wb_t struct: valid, reg_write, mem_to_reg, alu, load, dest. Also reused by the hazard unit.
- One natural sub-module: wb_bypass_mux (address compare + select for one read port), instantiated twice. Omitted when WB_BYPASS_EN is undefined.

Test Plan:
- Reset, then mem_valid=1, reg_write=1, mem_to_reg=0, alu=0x0000002A, dest=5, one clock -> rf_wr=1, rf_din=0x2A, rf_addr_wr=5. Next edge: file reg5=0x2A and retired_count=1.
- Load path: mem_to_reg=1, load=0xDEADBEEF, alu=0x11, dest=7 -> rf_din=0xDEADBEEF. After write, reading r7 returns 0xDEADBEEF.
- dest=0, reg_write=1, alu=0x55 -> rf_wr=0. r0 reads 0, retired_count still increments.
- Bypass (WB_BYPASS_EN): WB writing 0x1234 to r3, rd_addr_a=3, rd_addr_b=3, rf ports=0x0 -> fwd_port_a=fwd_port_b=0x1234. Without macro: both 0x0.
- Stall held 4 cycles on a valid entry -> rf_wr stays 1 with constant data, retired_count +1 only after stall drops. Flush with stall -> entry written, counted once, next WB is a bubble (rf_wr=0).
- rst asserted during stall with valid entry -> next cycle rf_wr=0, retired_count=0, fwd ports pass rf ports.

Source files
------------

// File: rtl/reg_writeback_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reg_writeback_stage_pkg
// Brief   : Shared widths, the r0 constant and the MEM/WB record layout.
//           The record is also used by the hazard unit.
// Revision: 1.0 - initial release
// ============================================================================
package reg_writeback_stage_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic              mem_to_reg;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] load;
      logic [ADDR_W-1:0] dest;
   } mem_wb_t;

endpackage
`default_nettype wire

// File: rtl/reg_writeback_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : reg_writeback_stage_if
// Brief   : Bundle of MEM-stage inputs, register file write/read port and
//           decode bypass signals around the write-back stage.
// Revision: 1.0 - initial release
// ============================================================================
interface reg_writeback_stage_if;
   import reg_writeback_stage_pkg::*;

   logic              stall;
   logic              flush;
   logic              mem_valid;
   logic              mem_reg_write;
   logic              mem_mem_to_reg;
   logic [DATA_W-1:0] mem_alu_result;
   logic [DATA_W-1:0] mem_load_data;
   logic [ADDR_W-1:0] mem_dest;
   logic [DATA_W-1:0] rf_din;
   logic [ADDR_W-1:0] rf_addr_wr;
   logic              rf_wr;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rf_port_a;
   logic [DATA_W-1:0] rf_port_b;
   logic [DATA_W-1:0] fwd_port_a;
   logic [DATA_W-1:0] fwd_port_b;
   logic [31:0]       retired_count;

   // Pipeline / register file side that feeds the stage
   modport master (
      output stall, flush, mem_valid, mem_reg_write, mem_mem_to_reg,
             mem_alu_result, mem_load_data, mem_dest,
             rd_addr_a, rd_addr_b, rf_port_a, rf_port_b,
      input  rf_din, rf_addr_wr, rf_wr, fwd_port_a, fwd_port_b, retired_count
   );

   // The write-back stage itself
   modport slave (
      input  stall, flush, mem_valid, mem_reg_write, mem_mem_to_reg,
             mem_alu_result, mem_load_data, mem_dest,
             rd_addr_a, rd_addr_b, rf_port_a, rf_port_b,
      output rf_din, rf_addr_wr, rf_wr, fwd_port_a, fwd_port_b, retired_count
   );

endinterface
`default_nettype wire

// File: rtl/reg_writeback_stage_wb_bypass_mux.sv
`default_nettype none
// ============================================================================
// Module  : wb_bypass_mux
// Brief   : One decode read port bypass: r0 reads zero, an address that
//           matches the write in flight this cycle takes the write data,
//           otherwise the asynchronous register file output passes through.
// Revision: 1.0 - initial release
// ============================================================================
module wb_bypass_mux
   import reg_writeback_stage_pkg::*;
(
   input  wire logic [ADDR_W-1:0] rd_addr,
   input  wire logic [DATA_W-1:0] rf_port,
   input  wire logic              wr_en,
   input  wire logic [ADDR_W-1:0] wr_addr,
   input  wire logic [DATA_W-1:0] wr_data,
   output logic      [DATA_W-1:0] fwd
);

   // Select operand: r0 forcing first, then same-cycle write hit, else file
   always_comb begin
      fwd = rf_port;
      if (rd_addr == REG_ZERO) begin
         fwd = '0;
      end else if (wr_en && (rd_addr == wr_addr)) begin
         fwd = wr_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/reg_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module  : reg_writeback_stage
// Brief   : MEM/WB pipeline register, register file write port, decode
//           operand bypass and retired-instruction counter.
//           Optional macro WB_BYPASS_EN enables the same-cycle bypass; when
//           undefined the decode operands come straight from the file.
// Revision: 1.0 - initial release
// ============================================================================
module reg_writeback_stage
   import reg_writeback_stage_pkg::*;
(
   input  wire logic          clk,
   input  wire logic          rst,
   reg_writeback_stage_if.slave bus
);

   mem_wb_t     wb;
   logic [31:0] retired;
   logic        leave_wb;

   // MEM/WB register: reset, then flush (bubble), then stall (hold), else load
   always_ff @(posedge clk) begin
      if (rst) begin
         wb <= '0;
      end else if (bus.flush) begin
         wb.valid <= 1'b0;
      end else if (!bus.stall) begin
         wb.valid      <= bus.mem_valid;
         wb.reg_write  <= bus.mem_reg_write;
         wb.mem_to_reg <= bus.mem_mem_to_reg;
         wb.alu        <= bus.mem_alu_result;
         wb.load       <= bus.mem_load_data;
         wb.dest       <= bus.mem_dest;
      end
   end

   // Write port is purely a function of the held entry; r0 is never written
   assign bus.rf_din     = wb.mem_to_reg ? wb.load : wb.alu;
   assign bus.rf_addr_wr = wb.dest;
   assign bus.rf_wr      = wb.valid & wb.reg_write & (wb.dest != REG_ZERO);

   // An entry retires on the edge it leaves WB, so a long stall counts once
   assign leave_wb = wb.valid & (~bus.stall | bus.flush);

   // Retired-instruction counter, free-running wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         retired <= '0;
      end else if (leave_wb) begin
         retired <= retired + 32'd1;
      end
   end

   assign bus.retired_count = retired;

`ifdef WB_BYPASS_EN
   wb_bypass_mux u_bypass_a (
      .rd_addr (bus.rd_addr_a),
      .rf_port (bus.rf_port_a),
      .wr_en   (bus.rf_wr),
      .wr_addr (bus.rf_addr_wr),
      .wr_data (bus.rf_din),
      .fwd     (bus.fwd_port_a)
   );

   wb_bypass_mux u_bypass_b (
      .rd_addr (bus.rd_addr_b),
      .rf_port (bus.rf_port_b),
      .wr_en   (bus.rf_wr),
      .wr_addr (bus.rf_addr_wr),
      .wr_data (bus.rf_din),
      .fwd     (bus.fwd_port_b)
   );
`else
   // No bypass: hazard control stalls decode an extra cycle instead
   assign bus.fwd_port_a = bus.rf_port_a;
   assign bus.fwd_port_b = bus.rf_port_b;

   logic unused_rd_addr;
   assign unused_rd_addr = &{1'b0, bus.rd_addr_a, bus.rd_addr_b};
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_writeback_stage
// Brief   : Directed plus randomized bench for reg_writeback_stage with a
//           register file and an abstract reference model of the stage.
// Revision: 1.0 - initial release
// ============================================================================
module tb_reg_writeback_stage;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   reg_writeback_stage_if bus ();

   reg_writeback_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Register file driven by the DUT write port, asynchronous reads
   logic [31:0] rf [32];
   initial for (int i = 0; i < 32; i++) rf[i] = '0;
   always @(posedge clk) if (bus.rf_wr === 1'b1) rf[bus.rf_addr_wr] <= bus.rf_din;
   assign bus.rf_port_a = rf[bus.rd_addr_a];
   assign bus.rf_port_b = rf[bus.rd_addr_b];

   // ---------------- reference model ----------------
   bit          m_init  = 0;   // a reset has been seen
   bit          m_known = 0;   // WB fields are defined (not after a flush)
   bit          m_valid = 0;
   bit          m_rw    = 0;
   logic [31:0] m_data  = '0;
   logic [4:0]  m_dest  = '0;
   logic [31:0] m_count = '0;
   logic [31:0] m_rf [32];
   initial for (int i = 0; i < 32; i++) m_rf[i] = '0;

   function automatic bit m_wr();
      return m_valid && m_rw && (m_dest != 5'd0);
   endfunction

   function automatic logic [31:0] m_fwd(input logic [4:0] a);
`ifdef WB_BYPASS_EN
      if (a == 5'd0) return 32'd0;
      if (m_wr() && a == m_dest) return m_data;
`endif
      return m_rf[a];
   endfunction

   always @(posedge clk) begin
      if (m_wr()) m_rf[m_dest] = m_data;
      if (rst) begin
         m_count = 0;
      end else if (m_valid && (!bus.stall || bus.flush)) begin
         m_count = m_count + 1;
      end
      if (rst) begin
         m_init = 1; m_known = 1; m_valid = 0; m_rw = 0; m_data = 0; m_dest = 0;
      end else if (bus.flush) begin
         m_valid = 0; m_known = 0;
      end else if (!bus.stall) begin
         m_known = 1;
         m_valid = bus.mem_valid;
         m_rw    = bus.mem_reg_write;
         m_data  = bus.mem_mem_to_reg ? bus.mem_load_data : bus.mem_alu_result;
         m_dest  = bus.mem_dest;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, mid-way through the low phase
   always @(negedge clk) begin
      #3;
      if (m_init) begin
         chk("rf_wr", {31'd0, bus.rf_wr}, {31'd0, m_wr()});
         chk("retired_count", bus.retired_count, m_count);
         chk("fwd_port_a", bus.fwd_port_a, m_fwd(bus.rd_addr_a));
         chk("fwd_port_b", bus.fwd_port_b, m_fwd(bus.rd_addr_b));
         if (m_known) begin
            chk("rf_din", bus.rf_din, m_data);
            chk("rf_addr_wr", {27'd0, bus.rf_addr_wr}, {27'd0, m_dest});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_in(input bit v, input bit rw, input bit m2r,
                         input logic [31:0] alu, input logic [31:0] ld,
                         input logic [4:0] dest);
      bus.mem_valid      = v;
      bus.mem_reg_write  = rw;
      bus.mem_mem_to_reg = m2r;
      bus.mem_alu_result = alu;
      bus.mem_load_data  = ld;
      bus.mem_dest       = dest;
   endtask

   task automatic bubble();
      set_in(0, 0, 0, 32'h0, 32'h0, 5'd0);
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] exp_byp;
      rst = 1; bus.stall = 0; bus.flush = 0;
      bus.rd_addr_a = 0; bus.rd_addr_b = 0;
      bubble();
      repeat (3) nxt();
      rst = 0;                                   // N3
      #4;
      chk("reset rf_wr", {31'd0, bus.rf_wr}, 32'd0);
      chk("reset rf_din", bus.rf_din, 32'd0);
      chk("reset rf_addr_wr", {27'd0, bus.rf_addr_wr}, 32'd0);
      chk("reset count", bus.retired_count, 32'd0);

      nxt(); set_in(1, 1, 0, 32'h2A, 32'h0, 5'd5);            // N4
      nxt(); bubble(); #4;                                    // N5
      chk("alu rf_wr", {31'd0, bus.rf_wr}, 32'd1);
      chk("alu rf_din", bus.rf_din, 32'h2A);
      chk("alu rf_addr_wr", {27'd0, bus.rf_addr_wr}, 32'd5);
      chk("alu count before", bus.retired_count, 32'd0);
      nxt(); set_in(1, 1, 1, 32'h11, 32'hDEADBEEF, 5'd7); #4; // N6
      chk("alu count after", bus.retired_count, 32'd1);
      chk("file r5", rf[5], 32'h2A);
      nxt(); bubble(); #4;                                    // N7
      chk("load rf_din", bus.rf_din, 32'hDEADBEEF);
      chk("load rf_addr_wr", {27'd0, bus.rf_addr_wr}, 32'd7);
      nxt(); bus.rd_addr_a = 7; #4;                           // N8
      chk("read r7", bus.fwd_port_a, 32'hDEADBEEF);
      chk("load count", bus.retired_count, 32'd2);

      nxt(); set_in(1, 1, 0, 32'h55, 32'h0, 5'd0);            // N9
      nxt(); bubble(); #4;                                    // N10
      chk("r0 rf_wr", {31'd0, bus.rf_wr}, 32'd0);
      nxt(); bus.rd_addr_a = 0; #4;                           // N11
      chk("r0 count", bus.retired_count, 32'd3);
      chk("r0 read", bus.fwd_port_a, 32'd0);

      nxt(); set_in(1, 1, 0, 32'h1234, 32'h0, 5'd3);          // N12
      nxt(); bubble(); bus.rd_addr_a = 3; bus.rd_addr_b = 3; #4; // N13
`ifdef WB_BYPASS_EN
      exp_byp = 32'h1234;
`else
      exp_byp = 32'h0;
`endif
      chk("bypass a", bus.fwd_port_a, exp_byp);
      chk("bypass b", bus.fwd_port_b, exp_byp);

      nxt(); set_in(1, 1, 0, 32'hABCD, 32'h0, 5'd9);          // N14
      nxt(); bus.stall = 1; set_in(1, 1, 0, 32'hFFFF, 32'h0, 5'd10); #4; // N15
      chk("stall count", bus.retired_count, 32'd4);
      for (int k = 0; k < 3; k++) begin                       // N16..N18
         nxt(); #4;
         chk("stall rf_wr", {31'd0, bus.rf_wr}, 32'd1);
         chk("stall rf_din", bus.rf_din, 32'hABCD);
         chk("stall held count", bus.retired_count, 32'd4);
      end
      nxt(); bus.stall = 0; bubble(); #4;                     // N19
      chk("stall drop count", bus.retired_count, 32'd4);
      nxt(); #4;                                              // N20
      chk("stall retire count", bus.retired_count, 32'd5);
      chk("stall bubble rf_wr", {31'd0, bus.rf_wr}, 32'd0);

      nxt(); set_in(1, 1, 0, 32'h77, 32'h0, 5'd11);           // N21
      nxt(); bus.stall = 1; bus.flush = 1; set_in(1, 1, 0, 32'h88, 32'h0, 5'd12); #4; // N22
      chk("flush rf_din", bus.rf_din, 32'h77);
      nxt(); bus.flush = 0; #4;                               // N23
      chk("flush bubble rf_wr", {31'd0, bus.rf_wr}, 32'd0);
      chk("flush count", bus.retired_count, 32'd6);
      chk("flush r11", rf[11], 32'h77);
      nxt(); bus.stall = 0; bubble();                         // N24

      nxt(); set_in(1, 1, 0, 32'h99, 32'h0, 5'd12);           // N25
      nxt(); bus.stall = 1; bubble(); #4;                     // N26
      chk("pre-reset rf_wr", {31'd0, bus.rf_wr}, 32'd1);
      nxt(); rst = 1;                                         // N27
      nxt(); rst = 0; bus.stall = 0; bus.rd_addr_a = 12; bus.rd_addr_b = 5; #4; // N28
      chk("rst-stall rf_wr", {31'd0, bus.rf_wr}, 32'd0);
      chk("rst-stall count", bus.retired_count, 32'd0);
      chk("rst-stall fwd a", bus.fwd_port_a, 32'h99);
      chk("rst-stall fwd b", bus.fwd_port_b, 32'h2A);

      // Randomized traffic; small address range to provoke bypass hits
      for (int c = 0; c < 1500; c++) begin
         nxt();
         rst       = ($urandom_range(0, 199) == 0);
         bus.stall = ($urandom_range(0, 3) == 0);
         bus.flush = ($urandom_range(0, 9) == 0);
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1, $urandom, $urandom,
                5'($urandom_range(0, 7)));
         bus.rd_addr_a = 5'($urandom_range(0, 7));
         bus.rd_addr_b = 5'($urandom_range(0, 7));
      end
      nxt(); rst = 0; bus.stall = 0; bus.flush = 0; bubble();
      repeat (3) nxt();
      #4;
      for (int i = 0; i < 32; i++) chk($sformatf("file r%0d", i), rf[i], m_rf[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
